cam_read_port_arbiter: RTL

- Shares the single 32-entry x 32-bit read mux of the CAM/register-file datapath among NUM_REQ requesters.
- Arbitrates round-robin and drives the mux's 5-bit selector from a register.
- Captures the mux output and returns it to the granted requester with a fixed two-cycle latency.
- Supports locked bursts, so one requester can hold the port for up to MAX_BURST consecutive reads.

---
 rtl/cam_read_port_arbiter_pkg.sv | 7 +
 rtl/cam_read_port_arbiter_if.sv | 17 +
 rtl/cam_read_port_arbiter_rr_pick.sv | 27 ++
 rtl/cam_read_port_arbiter.sv | 93 +++++++++
 4 files changed

// File: rtl/cam_read_port_arbiter_pkg.sv
// cam_arb_pkg: shared widths, FSM state and index types for the CAM read-port arbiter
package cam_arb_pkg;
  localparam int IDX_W = 5;
  localparam int DATA_W = 32;
  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} arb_state_t;
  typedef logic [IDX_W-1:0] cam_idx_t;
endpackage

// File: rtl/cam_read_port_arbiter_if.sv
// cam_read_port_arbiter_if: requester-side bus (en/req/lock/idx in, gnt/rvalid/rdata/busy out)
interface cam_read_port_arbiter_if
  import cam_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
);
  logic                     en_i;
  logic [NUM_REQ-1:0]       req_i;
  logic [NUM_REQ-1:0]       lock_i;
  logic [NUM_REQ*IDX_W-1:0] idx_i;
  logic [NUM_REQ-1:0]       gnt_o;
  logic [NUM_REQ-1:0]       rvalid_o;
  logic [DATA_W-1:0]        rdata_o;
  logic                     busy_o;
  modport master (output en_i, req_i, lock_i, idx_i, input gnt_o, rvalid_o, rdata_o, busy_o);
  modport slave (input en_i, req_i, lock_i, idx_i, output gnt_o, rvalid_o, rdata_o, busy_o);
endinterface

// File: rtl/cam_read_port_arbiter_rr_pick.sv
// rr_priority_pick: first set req bit at or after ptr_i (modulo N); one-hot gnt_o, encoded idx_o, any_o
module rr_priority_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);
  logic [PW-1:0] j;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j = '0;
    for (int i = 0; i < N; i++) begin
      j = PW'((int'(ptr_i) + i) % N);
      if (!any_o && req_i[j]) begin
        any_o = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o = j;
      end
    end
  end
endmodule

// File: rtl/cam_read_port_arbiter.sv
// cam_read_port_arbiter: round-robin arbiter with locked bursts sharing one 32x32 read mux; clk/rst, bus (slave), sel_o to mux, mux_data_i back, 2-cycle read latency
module cam_read_port_arbiter
  import cam_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  cam_read_port_arbiter_if.slave  bus,
  output cam_idx_t                sel_o,
  input  logic [DATA_W-1:0]       mux_data_i
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  typedef logic [PW-1:0] rid_t;
  arb_state_t         state_q, state_d;
  rid_t               ptr_q, ptr_d, owner_q, owner_d, gid_q, gid_d, pick_idx, win;
  logic [CW-1:0]      cnt_q, cnt_d;
  cam_idx_t           sel_q, sel_d, win_idx;
  logic               v1_q, v1_d, accept, pick_any;
  logic [NUM_REQ-1:0] pick_gnt, gnt, rvalid_q, rvalid_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  rr_priority_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .req_i (bus.req_i),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );
  always_comb begin
    win = state_q == BURST ? owner_q : pick_idx;
    gnt = (rst || !bus.en_i) ? '0 :
          state_q == BURST ? (bus.req_i[owner_q] ? NUM_REQ'(1) << owner_q : '0) : pick_gnt;
    accept = |gnt;
    win_idx = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (rid_t'(k) == win) win_idx = bus.idx_i[k*IDX_W +: IDX_W];
    state_d = state_q;
    ptr_d = ptr_q;
    owner_d = owner_q;
    cnt_d = cnt_q;
    if (bus.en_i) begin
      if (state_q == IDLE) begin
        if (pick_any) begin
          ptr_d = pick_idx == rid_t'(NUM_REQ - 1) ? '0 : pick_idx + 1'b1;
          if (bus.lock_i[pick_idx] && MAX_BURST > 1) begin
            state_d = BURST;
            owner_d = pick_idx;
            cnt_d = CW'(1);
          end
        end
      end else begin
        // owner dropping req, dropping lock, or reaching the burst limit all end the burst
        cnt_d = cnt_q + 1'b1;
        if (!bus.req_i[owner_q] || !bus.lock_i[owner_q] || cnt_d == CW'(MAX_BURST)) state_d = IDLE;
      end
    end
    sel_d = accept ? win_idx : sel_q;
    gid_d = accept ? win : gid_q;
    v1_d = accept;
    rvalid_d = v1_q ? NUM_REQ'(1) << gid_q : '0;
    rdata_d = v1_q ? mux_data_i : rdata_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      owner_q <= '0;
      cnt_q <= '0;
      sel_q <= '0;
      gid_q <= '0;
      v1_q <= 1'b0;
      rvalid_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      owner_q <= owner_d;
      cnt_q <= cnt_d;
      sel_q <= sel_d;
      gid_q <= gid_d;
      v1_q <= v1_d;
      rvalid_q <= rvalid_d;
      rdata_q <= rdata_d;
    end
  end
  assign sel_o = sel_q;
  assign bus.gnt_o = gnt;
  assign bus.rvalid_o = rvalid_q;
  assign bus.rdata_o = rdata_q;
  assign bus.busy_o = state_q == BURST || v1_q;
endmodule
